// File: rtl/mem_block_mover.sv
// mem_block_mover: copies or fills a block of RAM words through a combinational-read, clocked-write port
module mem_block_mover #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, cnt;
  logic [DATA_W-1:0] data_q, fill_q;
  logic mode_q;
  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state; fill stays in WRITE, copy alternates READ/WRITE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (length == '0) ? DONE : (mode ? WRITE : READ);
      READ:    state_nx = WRITE;
      WRITE:   state_nx = (cnt == ADDR_W'(1)) ? DONE : (mode_q ? WRITE : READ);
      default: state_nx = IDLE;
    endcase
  end
  // RAM port and status outputs; load is gated by reset so the reset edge never writes
  always_comb begin
    busy        = state != IDLE;
    done        = state == DONE;
    mem_address = (state == READ) ? src_ptr : (state == WRITE) ? dst_ptr : '0;
    mem_in      = (state == WRITE) ? (mode_q ? fill_q : data_q) : '0;
    mem_load    = (state == WRITE) && reset_n;
  end
  // operand latches, read capture and pointer/count stepping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      data_q  <= '0;
      fill_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src_ptr <= src_addr;
          dst_ptr <= dst_addr;
          cnt     <= length;
          fill_q  <= fill_value;
          mode_q  <= mode;
        end
        READ: data_q <= mem_out;
        WRITE: begin
          dst_ptr <= dst_ptr + 1'b1;
          if (!mode_q) src_ptr <= src_ptr + 1'b1;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
